// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch slice.
//   XLEN               : datapath / address width
//   RESET_PC_DEFAULT   : default PC loaded on reset
//   NOP_INSTR_DEFAULT  : bubble instruction (addi x0,x0,0) shown while the IF/ID slot is empty
//   fetch_state_e      : fetch FSM encoding (IDLE/REQ/WAIT/HOLD)
//   pc_incr / pc_align : sequential-PC and word-alignment helpers
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [XLEN-1:0] WORD_MASK         = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_HOLD = 2'b11
  } fetch_state_e;

  // Wraps modulo 2^XLEN, so 0xFFFF_FFFC steps to 0x0000_0000.
  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] pc);
    return pc & WORD_MASK;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
//   req    : fetch request valid (fetch -> imem)
//   addr   : word-aligned fetch address (fetch -> imem)
//   ready  : imem accepts the request this cycle; req && ready is the handshake
//   rvalid : response data valid, at least one cycle after accept
//   rdata  : fetched instruction word
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/fetch_unit_skid.sv
// Single-entry {instr, pc} buffer catching a fetch response that arrives while
// the IF/ID slot is stalled.
//   clk, rst          : clock, synchronous active-low reset (clears the valid flag only)
//   load              : capture in_instr/in_pc
//   unload            : entry moved on to IF/ID this cycle
//   clear             : flush (redirect); wins over load/unload
//   out_valid/instr/pc: buffered entry
module fetch_unit_skid
  import fetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  always_ff @(posedge clk) begin
    if (!rst)        out_valid <= 1'b0;
    else if (clear)  out_valid <= 1'b0;
    else if (load)   out_valid <= 1'b1;
    else if (unload) out_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) begin
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding decode. Owns the PC, keeps exactly one imem
// request outstanding, and presents the IF/ID register {o_valid, o_instruct,
// o_currentPC}. Honours downstream stall and the EX redirect (redirect wins).
//   clk, rst        : clock, synchronous active-low reset
//   imem            : instruction-memory bus (master side)
//   i_stall         : decode cannot take the IF/ID contents this cycle
//   i_redirect      : control-flow change from EX, target i_redirect_pc
//   o_valid         : IF/ID holds a real instruction
//   o_instruct      : IF/ID instruction (NOP_INSTR while empty)
//   o_currentPC     : PC of o_instruct
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
)(
  input  logic            clk,
  input  logic            rst,
  fetch_unit_if.master    imem,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instruct,
  output logic [XLEN-1:0] o_currentPC
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            drop, drop_nxt;
  logic            accept;
  logic            slot_free;
  logic            flush;
  logic            load_mem;
  logic            load_skid;
  logic            skid_load;
  logic            skid_valid;
  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  // Request is a pure decode of registered state; address is the PC register.
  assign imem.req  = (state == ST_REQ);
  assign imem.addr = pc;

  assign accept    = (state == ST_REQ) && imem.ready;
  assign slot_free = !o_valid || !i_stall;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    drop_nxt  = drop;
    flush     = 1'b0;
    load_mem  = 1'b0;
    load_skid = 1'b0;
    skid_load = 1'b0;
    if (i_redirect) begin
      flush  = 1'b1;
      pc_nxt = pc_align(i_redirect_pc);
      if (state == ST_WAIT) begin
        // A response landing with the redirect is simply discarded; otherwise
        // the one still in flight must be swallowed when it shows up.
        state_nxt = imem.rvalid ? ST_REQ : ST_WAIT;
        drop_nxt  = !imem.rvalid;
      end else if (accept) begin
        state_nxt = ST_WAIT;
        drop_nxt  = 1'b1;
      end else begin
        state_nxt = ST_REQ;
      end
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_REQ;
        ST_REQ:  if (accept) state_nxt = ST_WAIT;
        ST_WAIT: begin
          if (imem.rvalid) begin
            state_nxt = ST_REQ;
            if (drop) begin
              drop_nxt = 1'b0;
            end else if (slot_free) begin
              load_mem = 1'b1;
              pc_nxt   = pc_incr(pc);
            end else begin
              skid_load = 1'b1;
              pc_nxt    = pc_incr(pc);
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!i_stall) begin
            load_skid = skid_valid;
            state_nxt = ST_REQ;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      drop  <= drop_nxt;
    end
  end

  fetch_unit_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .unload    (load_skid),
    .clear     (flush),
    .in_instr  (imem.rdata),
    .in_pc     (pc),
    .out_valid (skid_valid),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

  // IF/ID register boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      o_valid     <= 1'b0;
      o_instruct  <= NOP_INSTR;
      o_currentPC <= '0;
    end else if (flush) begin
      o_valid    <= 1'b0;
      o_instruct <= NOP_INSTR;
    end else if (load_mem) begin
      o_valid     <= 1'b1;
      o_instruct  <= imem.rdata;
      o_currentPC <= pc;
    end else if (load_skid) begin
      o_valid     <= 1'b1;
      o_instruct  <= skid_instr;
      o_currentPC <= skid_pc;
    end else if (o_valid && !i_stall) begin
      o_valid    <= 1'b0;
      o_instruct <= NOP_INSTR;
    end
  end

endmodule
